encoder_8to3_hs: RTL and testbench
==================================

ENCODER_8TO3_HS -- requirements
Module: encoder_8to3_hs

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 G  input  1  active-low enable; 1 = disabled.
REQ-005 req_n  input  8  active-low one-cold request lines, in the same format the team's 3-to-8 decoder drives: code k asserts bit (7-k) low.
REQ-006 ack  input  1  consumer acknowledge, sampled only while valid=1.
REQ-007 C, B, A  output  1 each  registered encoded code {C,B,A}, with C as the MSB.
REQ-008 valid  output  1  high while {C,B,A} holds an unacknowledged code.
REQ-009 multi  output  1  high with valid when more than one request line was low at capture.
REQ-010 count  output  8  number of acknowledged encodings.

Function
REQ-011 req_n SHALL be registered into req_q each clock; the FSM evaluates req_q only, never req_n directly.
REQ-012 Encoding SHALL invert the decoder map:
 - req_q bit (7-k) low -> code k.
 - Priority goes to the lowest code, i.e. req_q[7] is highest priority and req_q[0] is lowest.
REQ-013 The FSM SHALL have exactly three states: IDLE, HOLD, RELEASE.
REQ-014 IDLE -> HOLD when G=0 and req_q != 8'hFF.
 - On that edge: load {C,B,A} with the priority code, set valid=1, and set multi=1 if two or more req_q bits are 0.
REQ-015 Latency: a request applied before edge t SHALL produce valid=1 after edge t+1, i.e. a 2-cycle latency.
REQ-016 In HOLD, {C,B,A} and multi SHALL stay stable regardless of req_n changes until ack or abort.
REQ-017 HOLD -> RELEASE on the first edge with ack=1 and G=0.
 - On that edge: valid=0, multi=0, count increments by 1.
 - {C,B,A} keeps its last value.
REQ-018 RELEASE -> IDLE when req_q == 8'hFF, so a request held high-duration is encoded exactly once.
REQ-019 G=1 SHALL force the next state to IDLE from any state.
 - valid=0 and multi=0 on that edge, with no count increment.
 - G=1 together with ack=1 in HOLD: the abort wins and count is unchanged.
REQ-020 After an abort, if G returns to 0 while a request is still held, that request SHALL be captured again as a new encoding.
REQ-021 ack while valid=0 SHALL be ignored.
REQ-022 count SHALL wrap modulo 256 (8'hFF + 1 -> 8'h00).
REQ-023 req_q == 8'hFF in IDLE, and all-ones inputs in general, SHALL produce no capture and no output change.
REQ-024 All outputs SHALL be driven from flops, with no combinational path from inputs to outputs.

Reset
REQ-025 While rst_n=0, independent of clk, the block SHALL hold:
 - state = IDLE
 - req_q = 8'hFF
 - {C,B,A} = 3'b000
 - valid = 0, multi = 0, count = 8'h00
REQ-026 Reset asserted mid-HOLD or mid-RELEASE SHALL discard the pending code with no count change beyond the reset value.
REQ-027 After rst_n rises, the first capture SHALL follow REQ-014/REQ-015 timing.

Verification
REQ-028 Round trip: drive each code k=0..7 through the decoder into req_n with G=0, ack one cycle after valid -> {C,B,A}=k, multi=0, count=8 at the end.
REQ-029 Priority: req_n=8'b11011011 -> {C,B,A}=3'b010, multi=1; ack -> count +1, valid=0.
REQ-030 Hold-once: req_n=8'b11110111 held 20 cycles with ack pulsed at every valid -> exactly one encoding (count +1), state stays in RELEASE until req_n=8'hFF.
REQ-031 Abort: in HOLD, drive G=1 and ack=1 together -> valid=0, count unchanged; drive G=0 with the request still held -> new capture 2 cycles later.
REQ-032 Wrap and reset: 256 acknowledged encodings -> count=8'h00; then assert rst_n=0 mid-HOLD asynchronously -> all outputs at reset values with no clock edge.
REQ-033 Disabled: G=1 with req_n=8'h00 for 10 cycles -> valid stays 0 and count is unchanged.

Source files
------------

// File: rtl/encoder_8to3_hs.sv
// Registered 8-to-3 priority encoder with a handshake: captures one active-low request,
// holds the code until acknowledged, then waits for all request lines to release.
module encoder_8to3_hs (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       G,
  input  logic [7:0] req_n,
  input  logic       ack,
  output logic       C,
  output logic       B,
  output logic       A,
  output logic       valid,
  output logic       multi,
  output logic [7:0] count
);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

  state_t     state_q, state_d;
  logic [7:0] req_q;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       multi_q, multi_d;
  logic [7:0] count_q, count_d;
  logic [2:0] prioCode;
  logic [3:0] lowCount;
  logic       manyReq;

  // Ascending scan so the highest low bit (lowest code) is assigned last and wins.
  always_comb begin
    prioCode = 3'd0;
    lowCount = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (!req_q[i]) begin
        prioCode = 3'(7 - i);
        lowCount = lowCount + 4'd1;
      end
    end
    manyReq = (lowCount > 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      req_q   <= req_n;
    end
  end

  always_comb begin
    state_d = state_q;
    if (G) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (req_q != 8'hFF) state_d = HOLD;
        HOLD:    if (ack) state_d = RELEASE;
        RELEASE: if (req_q == 8'hFF) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // An abort via G wins over an acknowledge, so the count only moves on a clean HOLD exit.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    multi_d = multi_q;
    count_d = count_q;
    if (G) begin
      valid_d = 1'b0;
      multi_d = 1'b0;
    end else if (state_q == IDLE && req_q != 8'hFF) begin
      code_d  = prioCode;
      valid_d = 1'b1;
      multi_d = manyReq;
    end else if (state_q == HOLD && ack) begin
      valid_d = 1'b0;
      multi_d = 1'b0;
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= 3'b000;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      count_q <= 8'h00;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      count_q <= count_d;
    end
  end

  assign {C, B, A} = code_q;
  assign valid     = valid_q;
  assign multi     = multi_q;
  assign count     = count_q;

endmodule

// File: tb/tb_encoder_8to3_hs.sv
// Bench for encoder_8to3_hs: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of the handshake encoder.
module tb_encoder_8to3_hs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       G;
  logic [7:0] req_n;
  logic       ack;
  logic       C, B, A;
  logic       valid, multi;
  logic [7:0] count;

  int checksTotal  = 0;
  int checksPassed = 0;

  // Model state: pending code, whether it awaits ack, whether we await full release.
  logic [7:0] mReqQ;
  logic [2:0] mCode;
  bit         mValid, mMulti, mWaitFree;
  logic [7:0] mCount;

  encoder_8to3_hs dut (
    .clk   (clk),
    .rst_n (rst_n),
    .G     (G),
    .req_n (req_n),
    .ack   (ack),
    .C     (C),
    .B     (B),
    .A     (A),
    .valid (valid),
    .multi (multi),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
  endtask

  function automatic void resetModel();
    mReqQ = 8'hFF; mCode = 3'd0; mValid = 0; mMulti = 0; mWaitFree = 0; mCount = 8'h00;
  endfunction

  function automatic void modelStep(input logic g, input logic [7:0] req, input logic a);
    int lows;
    bit found;
    if (g) begin
      mValid = 0; mMulti = 0; mWaitFree = 0;
    end else if (mValid) begin
      if (a) begin
        mValid = 0; mMulti = 0; mWaitFree = 1; mCount = mCount + 8'd1;
      end
    end else if (mWaitFree) begin
      if (mReqQ == 8'hFF) mWaitFree = 0;
    end else if (mReqQ != 8'hFF) begin
      found = 0;
      for (int k = 0; k < 8; k++)
        if (!found && mReqQ[7-k] == 1'b0) begin
          mCode = 3'(k);
          found = 1;
        end
      lows = 8 - $countones(mReqQ);
      mMulti = (lows >= 2);
      mValid = 1;
    end
    mReqQ = req;
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, ".code"},  {5'd0, C, B, A}, {5'd0, mCode});
    checkOutput({tag, ".valid"}, {7'd0, valid},   {7'd0, mValid});
    checkOutput({tag, ".multi"}, {7'd0, multi},   {7'd0, mMulti});
    checkOutput({tag, ".count"}, count,           mCount);
  endtask

  task automatic applyStimulus(input logic g, input logic [7:0] req, input logic a, input string tag);
    G = g; req_n = req; ack = a;
    @(posedge clk);
    modelStep(g, req, a);
    #1;
    compareAll(tag);
  endtask

  task automatic waitValid(input logic [7:0] req, input string tag);
    for (int i = 0; i < 6 && valid !== 1'b1; i++) applyStimulus(1'b0, req, 1'b0, tag);
    checkOutput({tag, ".timeout"}, {7'd0, valid}, 8'd1);
  endtask

  task automatic doEncoding(input logic [7:0] req, input string tag);
    waitValid(req, tag);
    applyStimulus(1'b0, req, 1'b1, tag);
    applyStimulus(1'b0, 8'hFF, 1'b0, tag);
    applyStimulus(1'b0, 8'hFF, 1'b0, tag);
    applyStimulus(1'b0, 8'hFF, 1'b0, tag);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".code"},  {5'd0, C, B, A}, 8'd0);
    checkOutput({tag, ".valid"}, {7'd0, valid},   8'd0);
    checkOutput({tag, ".multi"}, {7'd0, multi},   8'd0);
    checkOutput({tag, ".count"}, count,           8'h00);
  endtask

  initial begin
    logic [7:0] saved;
    logic [7:0] req;
    resetModel();
    rst_n = 1'b0; G = 1'b1; req_n = 8'hFF; ack = 1'b0;
    #13;
    checkResetValues("reset");
    @(negedge clk) rst_n = 1'b1;

    // Round trip through the decoder format, then latency of the first capture.
    for (int k = 0; k < 8; k++) begin
      req = ~(8'h80 >> k);
      applyStimulus(1'b0, req, 1'b0, "rt.apply");
      applyStimulus(1'b0, req, 1'b0, "rt.lat1");
      checkOutput("rt.validAtT1", {7'd0, valid}, 8'd1);
      checkOutput("rt.code", {5'd0, C, B, A}, 8'(k));
      checkOutput("rt.multi", {7'd0, multi}, 8'd0);
      applyStimulus(1'b0, req, 1'b1, "rt.ack");
      applyStimulus(1'b0, 8'hFF, 1'b0, "rt.rel");
      applyStimulus(1'b0, 8'hFF, 1'b0, "rt.rel");
      applyStimulus(1'b0, 8'hFF, 1'b0, "rt.rel");
    end
    checkOutput("rt.count8", count, 8'd8);

    // Priority between two simultaneous requests.
    waitValid(8'b11011011, "prio");
    checkOutput("prio.code", {5'd0, C, B, A}, 8'd2);
    checkOutput("prio.multi", {7'd0, multi}, 8'd1);
    saved = count;
    applyStimulus(1'b0, 8'b11011011, 1'b1, "prio.ack");
    checkOutput("prio.count", count, saved + 8'd1);
    checkOutput("prio.validLow", {7'd0, valid}, 8'd0);
    applyStimulus(1'b0, 8'b11110000, 1'b0, "prio.change");
    applyStimulus(1'b0, 8'hFF, 1'b0, "prio.rel");
    applyStimulus(1'b0, 8'hFF, 1'b0, "prio.rel");

    // A long-held request is encoded exactly once even with ack at every valid.
    saved = count;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'b11110111, valid, "hold");
    checkOutput("hold.once", count, saved + 8'd1);
    checkOutput("hold.noValid", {7'd0, valid}, 8'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hFF, 1'b1, "hold.rel");

    // Abort with simultaneous ack, then recapture of the still-held request.
    waitValid(8'b11111110, "abort");
    saved = count;
    applyStimulus(1'b1, 8'b11111110, 1'b1, "abort.g");
    checkOutput("abort.valid", {7'd0, valid}, 8'd0);
    checkOutput("abort.count", count, saved);
    applyStimulus(1'b0, 8'b11111110, 1'b0, "abort.re");
    checkOutput("abort.recap", {7'd0, valid}, 8'd1);
    checkOutput("abort.code", {5'd0, C, B, A}, 8'd7);
    applyStimulus(1'b0, 8'b11111110, 1'b1, "abort.ack");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hFF, 1'b0, "abort.rel");

    // Disabled with every request line low.
    saved = count;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h00, 1'b1, "dis");
    checkOutput("dis.valid", {7'd0, valid}, 8'd0);
    checkOutput("dis.count", count, saved);
    applyStimulus(1'b1, 8'hFF, 1'b0, "dis.rel");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    req = 8'hFF;
        2:       req = ~(8'h01 << $urandom_range(0, 7));
        default: req = 8'($urandom);
      endcase
      applyStimulus($urandom_range(0, 9) == 0, req, 1'($urandom_range(0, 1)), "rand");
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hFF, 1'b0, "rand.rel");

    // Fresh reset, 256 acknowledged encodings wrap the count back to zero.
    #2 rst_n = 1'b0;
    resetModel();
    #1 checkResetValues("rst2");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 256; i++) doEncoding(~(8'h01 << (i % 8)), "wrap");
    checkOutput("wrap.count0", count, 8'h00);

    // Asynchronous reset in the middle of HOLD.
    waitValid(8'b10111111, "midhold");
    #2 rst_n = 1'b0;
    #1 checkResetValues("midhold.rst");
    resetModel();
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(1'b0, 8'hFF, 1'b0, "post.idle");
    applyStimulus(1'b0, 8'b01111111, 1'b0, "post.apply");
    applyStimulus(1'b0, 8'b01111111, 1'b0, "post.lat");
    checkOutput("post.valid", {7'd0, valid}, 8'd1);
    checkOutput("post.code", {5'd0, C, B, A}, 8'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
